mode_sequencer: RTL and testbench

MODE_SEQUENCER -- requirements
Module: mode_sequencer

---
 rtl/mode_seq_pkg.sv | 40 ++++
 rtl/sec_countdown.sv | 26 ++
 rtl/mode_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mode_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mode_seq_pkg.sv
// Shared definitions for the fan mode sequencer: mode codes, packed state
// layout, default durations and the state packing helper.
package mode_seq_pkg;

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_STANDBY = 3'd1,
    M_GEAR1   = 3'd2,
    M_GEAR2   = 3'd3,
    M_GEAR3   = 3'd4,
    M_CLEAN   = 3'd5
  } mode_e;

  // Plain constants keep the FSM readable by older tools that dislike enums
  localparam logic [2:0] ST_OFF     = M_OFF;
  localparam logic [2:0] ST_STANDBY = M_STANDBY;
  localparam logic [2:0] ST_GEAR1   = M_GEAR1;
  localparam logic [2:0] ST_GEAR2   = M_GEAR2;
  localparam logic [2:0] ST_GEAR3   = M_GEAR3;
  localparam logic [2:0] ST_CLEAN   = M_CLEAN;

  localparam int POWER_BIT = 6;
  localparam int MODE_MSB  = 5;
  localparam int MODE_LSB  = 3;
  localparam int PAUSE_BIT = 2;

  localparam int DEF_HURRICANE_S = 60;
  localparam int DEF_CLEAN_S     = 180;
  localparam int DEF_IDLE_S      = 30;

  function automatic logic [6:0] pack_state(input logic [2:0] mode, input logic paused);
    logic [6:0] s;
    s = '0;
    s[POWER_BIT]         = (mode != ST_OFF);
    s[MODE_MSB:MODE_LSB] = mode;
    s[PAUSE_BIT]         = paused;
    return s;
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Seconds countdown shared by the timed modes; expire flags the tick that
// takes the count from 1 to 0 so the caller can switch mode on the same edge.
module sec_countdown (
  input  logic       clk,
  input  logic       buttom_rst,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       tick,
  input  logic       pause,
  output logic [7:0] remain,
  output logic       expire
);

  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      remain <= '0;
    end else if (load) begin
      remain <= value;
    end else if (tick && !pause && remain != 8'd0) begin
      remain <= remain - 8'd1;
    end
  end

  assign expire = tick && !pause && !load && (remain == 8'd1);

endmodule

// File: rtl/mode_sequencer.sv
// Fan mode sequencer: power, three gears with a one-shot timed hurricane gear
// and a pausable self-clean. STANDBY auto-off exists only with MODE_SEQ_AUTO_OFF_EN.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int HURRICANE_S = DEF_HURRICANE_S,
  parameter int CLEAN_S     = DEF_CLEAN_S,
  parameter int IDLE_S      = DEF_IDLE_S
) (
  input  logic       clk,
  input  logic       buttom_rst,
  input  logic       sign_pos_A,
  input  logic       sign_pos_S,
  input  logic       sign_pos_W,
  input  logic       sign_pos_X,
  input  logic       sign_pos_D,
  input  logic       tick_1s,
  output logic [6:0] state,
  output logic [7:0] remain_s,
  output logic       done
);

  if (HURRICANE_S < 1 || HURRICANE_S > 255) begin : g_bad_hurricane
    $error("HURRICANE_S must be in 1..255");
  end
  if (CLEAN_S < 1 || CLEAN_S > 255) begin : g_bad_clean
    $error("CLEAN_S must be in 1..255");
  end
  if (IDLE_S < 1 || IDLE_S > 255) begin : g_bad_idle
    $error("IDLE_S must be in 1..255");
  end

  logic [6:0] state_q;
  logic       done_q;
  logic       hurricane_used;
  logic [2:0] mode;
  logic       paused;
  logic       acc_a, acc_d, acc_w, acc_x, acc_s, any_acc;
  logic [2:0] mode_n;
  logic       paused_n, hurricane_n, done_n;
  logic       cnt_load, cnt_tick, cnt_expire;
  logic [7:0] cnt_value;
  logic       idle_hit;

  assign mode   = state_q[MODE_MSB:MODE_LSB];
  assign paused = state_q[PAUSE_BIT];

  // A pulse is accepted only if it would do something in the current mode
  always_comb begin
    acc_a   = sign_pos_A;
    acc_d   = sign_pos_D && (mode == ST_STANDBY);
    acc_w   = sign_pos_W && ((mode == ST_STANDBY) || (mode == ST_GEAR1) ||
                             (mode == ST_GEAR2 && !hurricane_used));
    acc_x   = sign_pos_X && ((mode == ST_GEAR1) || (mode == ST_GEAR2) || (mode == ST_GEAR3));
    acc_s   = sign_pos_S && (mode == ST_CLEAN);
    any_acc = acc_a || acc_d || acc_w || acc_x || acc_s;
  end

  assign cnt_tick = tick_1s && !any_acc;

`ifdef MODE_SEQ_AUTO_OFF_EN
  logic [7:0] idle_cnt;

  assign idle_hit = (mode == ST_STANDBY) && tick_1s && !any_acc &&
                    (idle_cnt == 8'(IDLE_S - 1));

  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      idle_cnt <= '0;
    end else if (mode != ST_STANDBY || any_acc || mode_n != mode) begin
      idle_cnt <= '0;
    end else if (tick_1s) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  // Priority chain A > D > W > X > S, then countdown expiry, then auto-off
  always_comb begin
    mode_n      = mode;
    paused_n    = paused;
    hurricane_n = hurricane_used;
    done_n      = 1'b0;
    cnt_load    = 1'b0;
    cnt_value   = '0;
    if (acc_a) begin
      if (mode == ST_OFF) begin
        mode_n = ST_STANDBY;
      end else begin
        mode_n      = ST_OFF;
        paused_n    = 1'b0;
        hurricane_n = 1'b0;
        cnt_load    = 1'b1;
      end
    end else if (acc_d) begin
      mode_n    = ST_CLEAN;
      cnt_load  = 1'b1;
      cnt_value = 8'(CLEAN_S);
    end else if (acc_w) begin
      case (mode)
        ST_STANDBY: mode_n = ST_GEAR1;
        ST_GEAR1:   mode_n = ST_GEAR2;
        default: begin
          mode_n      = ST_GEAR3;
          hurricane_n = 1'b1;
          cnt_load    = 1'b1;
          cnt_value   = 8'(HURRICANE_S);
        end
      endcase
    end else if (acc_x) begin
      case (mode)
        ST_GEAR1: mode_n = ST_STANDBY;
        ST_GEAR2: mode_n = ST_GEAR1;
        default: begin
          mode_n   = ST_GEAR2;
          cnt_load = 1'b1;
        end
      endcase
    end else if (acc_s) begin
      paused_n = !paused;
    end else if (cnt_expire) begin
      done_n = 1'b1;
      if (mode == ST_GEAR3) begin
        mode_n = ST_GEAR2;
      end else begin
        mode_n   = ST_STANDBY;
        paused_n = 1'b0;
      end
    end else if (idle_hit) begin
      mode_n = ST_OFF;
    end
  end

  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      state_q        <= '0;
      done_q         <= 1'b0;
      hurricane_used <= 1'b0;
    end else begin
      state_q        <= pack_state(mode_n, paused_n);
      done_q         <= done_n;
      hurricane_used <= hurricane_n;
    end
  end

  sec_countdown u_countdown (
    .clk        (clk),
    .buttom_rst (buttom_rst),
    .load       (cnt_load),
    .value      (cnt_value),
    .tick       (cnt_tick),
    .pause      (paused),
    .remain     (remain_s),
    .expire     (cnt_expire)
  );

  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: stimulus queues the expected outputs of
// each cycle, a monitor pops and compares them after every clock edge.
module tb_mode_sequencer;

  logic       clk = 1'b0;
  logic       buttom_rst;
  logic       sign_pos_A, sign_pos_S, sign_pos_W, sign_pos_X, sign_pos_D;
  logic       tick_1s;
  logic [6:0] state;
  logic [7:0] remain_s;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [6:0] st;
    logic [7:0] rem;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [6:0] S_OFF = 7'b0000000;
  localparam logic [6:0] S_SB  = 7'b1001000;
  localparam logic [6:0] S_G1  = 7'b1010000;
  localparam logic [6:0] S_G2  = 7'b1011000;
  localparam logic [6:0] S_G3  = 7'b1100000;
  localparam logic [6:0] S_CL  = 7'b1101000;
  localparam logic [6:0] S_CLP = 7'b1101100;

  // Pulse vector order: {A, D, W, X, S}
  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_A    = 5'b10000;
  localparam logic [4:0] P_D    = 5'b01000;
  localparam logic [4:0] P_W    = 5'b00100;
  localparam logic [4:0] P_X    = 5'b00010;
  localparam logic [4:0] P_S    = 5'b00001;

  mode_sequencer dut (
    .clk        (clk),
    .buttom_rst (buttom_rst),
    .sign_pos_A (sign_pos_A),
    .sign_pos_S (sign_pos_S),
    .sign_pos_W (sign_pos_W),
    .sign_pos_X (sign_pos_X),
    .sign_pos_D (sign_pos_D),
    .tick_1s    (tick_1s),
    .state      (state),
    .remain_s   (remain_s),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [6:0] es,
                             input logic [7:0] er, input logic ed);
    checks++;
    if (state !== es || remain_s !== er || done !== ed) begin
      errors++;
      $display("[TB] FAIL %s: got state=%b remain_s=%0d done=%b, expected state=%b remain_s=%0d done=%b",
               name, state, remain_s, done, es, er, ed);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [4:0] p, input logic tk,
                               input logic [6:0] es, input logic [7:0] er, input logic ed);
    exp_t e;
    @(negedge clk);
    {sign_pos_A, sign_pos_D, sign_pos_W, sign_pos_X, sign_pos_S} = p;
    tick_1s = tk;
    e.name = name;
    e.st   = es;
    e.rem  = er;
    e.dn   = ed;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    {sign_pos_A, sign_pos_D, sign_pos_W, sign_pos_X, sign_pos_S} = P_NONE;
    tick_1s = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.name, e.st, e.rem, e.dn);
      end
    end
  end

  initial begin
    buttom_rst = 1'b1;
    {sign_pos_A, sign_pos_D, sign_pos_W, sign_pos_X, sign_pos_S} = P_NONE;
    tick_1s = 1'b0;
    #1 buttom_rst = 1'b0;
    #10;
    checkOutput("reset_state", S_OFF, 8'd0, 1'b0);
    @(negedge clk);
    buttom_rst = 1'b1;

    applyStimulus("idle_off",       P_NONE, 1'b0, S_OFF, 8'd0, 1'b0);
    applyStimulus("w_ignored_off",  P_W,    1'b0, S_OFF, 8'd0, 1'b0);
    applyStimulus("a_standby",      P_A,    1'b0, S_SB,  8'd0, 1'b0);
    applyStimulus("x_ignored_sb",   P_X,    1'b0, S_SB,  8'd0, 1'b0);
    applyStimulus("w_gear1",        P_W,    1'b0, S_G1,  8'd0, 1'b0);
    applyStimulus("w_gear2",        P_W,    1'b0, S_G2,  8'd0, 1'b0);
    applyStimulus("d_ignored_g2",   P_D,    1'b0, S_G2,  8'd0, 1'b0);
    applyStimulus("w_gear3",        P_W,    1'b0, S_G3,  8'd60, 1'b0);
    for (int i = 1; i <= 59; i++)
      applyStimulus("g3_tick",      P_NONE, 1'b1, S_G3,  8'(60 - i), 1'b0);
    applyStimulus("g3_expire",      P_NONE, 1'b1, S_G2,  8'd0, 1'b1);
    applyStimulus("g3_done_drop",   P_NONE, 1'b0, S_G2,  8'd0, 1'b0);
    applyStimulus("w_hurr_used",    P_W,    1'b0, S_G2,  8'd0, 1'b0);
    applyStimulus("a_off",          P_A,    1'b0, S_OFF, 8'd0, 1'b0);
    applyStimulus("a_on_again",     P_A,    1'b0, S_SB,  8'd0, 1'b0);
    applyStimulus("w_g1_again",     P_W,    1'b0, S_G1,  8'd0, 1'b0);
    applyStimulus("w_g2_again",     P_W,    1'b0, S_G2,  8'd0, 1'b0);
    applyStimulus("w_g3_again",     P_W,    1'b0, S_G3,  8'd60, 1'b0);
    applyStimulus("w_tick_g3",      P_W,    1'b1, S_G3,  8'd59, 1'b0);
    for (int i = 1; i <= 29; i++)
      applyStimulus("g3_tick2",     P_NONE, 1'b1, S_G3,  8'(59 - i), 1'b0);
    applyStimulus("x_tick_g3",      P_X,    1'b1, S_G2,  8'd0, 1'b0);
    applyStimulus("no_done_x",      P_NONE, 1'b0, S_G2,  8'd0, 1'b0);
    applyStimulus("x_gear1",        P_X,    1'b0, S_G1,  8'd0, 1'b0);
    applyStimulus("a_w_same",       P_A | P_W, 1'b0, S_OFF, 8'd0, 1'b0);
    applyStimulus("a_standby2",     P_A,    1'b0, S_SB,  8'd0, 1'b0);

    applyStimulus("d_clean",        P_D,    1'b0, S_CL,  8'd180, 1'b0);
    for (int i = 1; i <= 10; i++)
      applyStimulus("clean_tick",   P_NONE, 1'b1, S_CL,  8'(180 - i), 1'b0);
    applyStimulus("s_pause",        P_S,    1'b0, S_CLP, 8'd170, 1'b0);
    for (int i = 1; i <= 5; i++)
      applyStimulus("paused_tick",  P_NONE, 1'b1, S_CLP, 8'd170, 1'b0);
    applyStimulus("s_resume",       P_S,    1'b0, S_CL,  8'd170, 1'b0);
    applyStimulus("w_ignored_cl",   P_W,    1'b0, S_CL,  8'd170, 1'b0);
    applyStimulus("x_ignored_cl",   P_X,    1'b0, S_CL,  8'd170, 1'b0);
    applyStimulus("s_tick_pause",   P_S,    1'b1, S_CLP, 8'd170, 1'b0);
    applyStimulus("s_tick_resume",  P_S,    1'b1, S_CL,  8'd170, 1'b0);
    for (int i = 1; i <= 169; i++)
      applyStimulus("clean_tick2",  P_NONE, 1'b1, S_CL,  8'(170 - i), 1'b0);
    applyStimulus("clean_expire",   P_NONE, 1'b1, S_SB,  8'd0, 1'b1);
    applyStimulus("clean_done_drop", P_NONE, 1'b0, S_SB, 8'd0, 1'b0);

    applyStimulus("d_w_prio",       P_D | P_W, 1'b0, S_CL, 8'd180, 1'b0);
    for (int i = 1; i <= 90; i++)
      applyStimulus("clean_tick3",  P_NONE, 1'b1, S_CL,  8'(180 - i), 1'b0);
    @(negedge clk);
    #2 buttom_rst = 1'b0;
    #1;
    checkOutput("async_reset", S_OFF, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", S_OFF, 8'd0, 1'b0);
    @(negedge clk);
    buttom_rst = 1'b1;
    applyStimulus("after_reset",    P_NONE, 1'b1, S_OFF, 8'd0, 1'b0);
    applyStimulus("a_standby3",     P_A,    1'b0, S_SB,  8'd0, 1'b0);

`ifdef MODE_SEQ_AUTO_OFF_EN
    for (int i = 1; i <= 28; i++)
      applyStimulus("idle_tick",    P_NONE, 1'b1, S_SB,  8'd0, 1'b0);
    applyStimulus("w_at_tick29",    P_W,    1'b1, S_G1,  8'd0, 1'b0);
    applyStimulus("x_back_sb",      P_X,    1'b0, S_SB,  8'd0, 1'b0);
    for (int i = 1; i <= 29; i++)
      applyStimulus("idle_tick2",   P_NONE, 1'b1, S_SB,  8'd0, 1'b0);
    applyStimulus("auto_off",       P_NONE, 1'b1, S_OFF, 8'd0, 1'b0);
    applyStimulus("auto_off_hold",  P_NONE, 1'b0, S_OFF, 8'd0, 1'b0);
`else
    for (int i = 1; i <= 300; i++)
      applyStimulus("sb_persist",   P_NONE, 1'b1, S_SB,  8'd0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
